// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU operation and control-state definitions for the 8-bit CPU
package cpu_pkg;
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [2:0] ALU_FWD  = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
endpackage

// File: rtl/cpu_ctrl_unit_if.sv
// cpu_ctrl_unit_if: instruction-memory busy-wait fetch bus between the control unit and IMEM
interface cpu_ctrl_unit_if;
   logic [31:0] PC;
   logic        IMEM_READ;
   logic        IMEM_BUSYWAIT;
   logic [31:0] INSTRUCTION;
   modport master (output PC, IMEM_READ, input IMEM_BUSYWAIT, INSTRUCTION);
   modport slave  (input PC, IMEM_READ, output IMEM_BUSYWAIT, INSTRUCTION);
endinterface

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational opcode decoder; j/beq are only legal when CPU_CTRL_BRANCH_EN is defined
module cpu_ctrl_decode
   import cpu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic       write,
   output logic [2:0] aluop,
   output logic       imm_sel,
   output logic       neg_sel,
   output logic       is_jump,
   output logic       is_beq,
   output logic       is_illegal
);
   // anything not listed is illegal and decodes to an inert no-op
   always_comb begin
      write      = 1'b0;
      aluop      = ALU_FWD;
      imm_sel    = 1'b0;
      neg_sel    = 1'b0;
      is_jump    = 1'b0;
      is_beq     = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_LOADI: begin write = 1'b1; imm_sel = 1'b1; end
         OP_MOV:   write = 1'b1;
         OP_ADD:   begin write = 1'b1; aluop = ALU_ADD; end
         OP_SUB:   begin write = 1'b1; aluop = ALU_ADD; neg_sel = 1'b1; end
         OP_AND:   begin write = 1'b1; aluop = ALU_AND; end
         OP_OR:    begin write = 1'b1; aluop = ALU_OR; end
`ifdef CPU_CTRL_BRANCH_EN
         OP_J:     is_jump = 1'b1;
         OP_BEQ:   begin aluop = ALU_ADD; neg_sel = 1'b1; is_beq = 1'b1; end
`endif
         default:  is_illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/cpu_ctrl_unit.sv
// cpu_ctrl_unit: PC/IR fetch FSM and control decode; CPU_CTRL_BRANCH_EN enables j/beq
module cpu_ctrl_unit
   import cpu_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RESET,
   cpu_ctrl_unit_if.master        imem,
   input  logic                   ZERO,
   output logic                   WRITE,
   output logic [2:0]             INADDRESS,
   output logic [2:0]             OUT1ADDRESS,
   output logic [2:0]             OUT2ADDRESS,
   output logic [7:0]             IMM,
   output logic [2:0]             ALUOP,
   output logic                   IMM_SEL,
   output logic                   NEG_SEL,
   output logic                   ILLEGAL
);
   state_t      state, next_state;
   logic [31:0] pc, ir, next_pc, offset;
   logic        exec, taken;
   logic        dec_write, dec_imm_sel, dec_neg_sel, is_jump, is_beq, is_illegal;
   logic [2:0]  dec_aluop;

   cpu_ctrl_decode u_decode (
      .opcode     (ir[31:24]),
      .write      (dec_write),
      .aluop      (dec_aluop),
      .imm_sel    (dec_imm_sel),
      .neg_sel    (dec_neg_sel),
      .is_jump    (is_jump),
      .is_beq     (is_beq),
      .is_illegal (is_illegal)
   );

   // state, PC, IR and sticky illegal flag; reset aborts any instruction in flight
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= IDLE;
         pc      <= '0;
         ir      <= '0;
         ILLEGAL <= 1'b0;
      end else begin
         state <= next_state;
         if (state == FETCH && !imem.IMEM_BUSYWAIT) ir <= imem.INSTRUCTION;
         if (exec) begin
            pc      <= next_pc;
            ILLEGAL <= ILLEGAL | is_illegal;
         end
      end
   end

   // next state, branch target and decoded controls, which are live only in EXEC
   always_comb begin
      exec        = state == EXEC;
      next_state  = state == IDLE ? FETCH :
                    state == FETCH ? (imem.IMEM_BUSYWAIT ? FETCH : EXEC) : FETCH;
      offset      = {{22{ir[23]}}, ir[23:16], 2'b00};
      taken       = is_jump | (is_beq & ZERO);
      next_pc     = pc + 32'd4 + (taken ? offset : 32'd0);
      imem.PC        = pc;
      imem.IMEM_READ = state == FETCH;
      WRITE       = exec & dec_write;
      ALUOP       = exec ? dec_aluop : ALU_FWD;
      IMM_SEL     = exec & dec_imm_sel;
      NEG_SEL     = exec & dec_neg_sel;
      INADDRESS   = exec ? ir[18:16] : 3'd0;
      OUT1ADDRESS = exec ? ir[10:8] : 3'd0;
      OUT2ADDRESS = exec ? ir[2:0] : 3'd0;
      IMM         = exec ? ir[7:0] : 8'd0;
   end
endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// tb_cpu_ctrl_unit: directed program run through the control unit with a small instruction memory
module tb_cpu_ctrl_unit;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        ZERO = 1'b0;
   logic        WRITE, IMM_SEL, NEG_SEL, ILLEGAL;
   logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
   logic [7:0]  IMM;
   logic [31:0] mem [16];
   int          errors = 0;
   int          checks = 0;
   int          writes = 0;

   cpu_ctrl_unit_if bus ();

   cpu_ctrl_unit dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .imem        (bus.master),
      .ZERO        (ZERO),
      .WRITE       (WRITE),
      .INADDRESS   (INADDRESS),
      .OUT1ADDRESS (OUT1ADDRESS),
      .OUT2ADDRESS (OUT2ADDRESS),
      .IMM         (IMM),
      .ALUOP       (ALUOP),
      .IMM_SEL     (IMM_SEL),
      .NEG_SEL     (NEG_SEL),
      .ILLEGAL     (ILLEGAL)
   );

   always #5 CLK = ~CLK;

   assign bus.INSTRUCTION = mem[bus.PC[5:2]];

   always @(posedge CLK) if (WRITE === 1'b1) writes++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // checks one FETCH (no wait states) then its EXEC cycle, leaving the bench in the next FETCH
   task automatic run(input string tag, input logic [31:0] pc, input logic wr, input logic [2:0] op);
      chk({tag, "_pc"}, bus.PC, pc);
      chk({tag, "_rd"}, {31'd0, bus.IMEM_READ}, 32'd1);
      @(negedge CLK);
      chk({tag, "_wr"}, {31'd0, WRITE}, {31'd0, wr});
      chk({tag, "_op"}, {29'd0, ALUOP}, {29'd0, op});
      chk({tag, "_rdx"}, {31'd0, bus.IMEM_READ}, 32'd0);
      @(negedge CLK);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'h0002001F;
      mem[1] = 32'h03040103;
      mem[2] = 32'h04050102;
      mem[3] = 32'h05060201;
      mem[4] = 32'h07FE0000;
      mem[5] = 32'h2A000000;
      mem[6] = 32'h02050607;
      bus.IMEM_BUSYWAIT = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_pc", bus.PC, 32'h0);
      chk("rst_rd", {31'd0, bus.IMEM_READ}, 32'd0);
      chk("rst_wr", {31'd0, WRITE}, 32'd0);
      chk("rst_ill", {31'd0, ILLEGAL}, 32'd0);
      RESET = 1'b1;
      #1 chk("idle_rd", {31'd0, bus.IMEM_READ}, 32'd0);
      @(negedge CLK);
      chk("f0_pc", bus.PC, 32'h0);
      chk("f0_rd", {31'd0, bus.IMEM_READ}, 32'd1);
      chk("f0_wr", {31'd0, WRITE}, 32'd0);
      @(negedge CLK);
      chk("ldi_wr", {31'd0, WRITE}, 32'd1);
      chk("ldi_rd", {29'd0, INADDRESS}, 32'd2);
      chk("ldi_imm", {24'd0, IMM}, 32'h1F);
      chk("ldi_isel", {31'd0, IMM_SEL}, 32'd1);
      chk("ldi_op", {29'd0, ALUOP}, 32'd0);
      @(negedge CLK);
      chk("sub_pc0", bus.PC, 32'h4);
      bus.IMEM_BUSYWAIT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("sub_hold_pc", bus.PC, 32'h4);
         chk("sub_hold_rd", {31'd0, bus.IMEM_READ}, 32'd1);
         chk("sub_hold_wr", {31'd0, WRITE}, 32'd0);
      end
      bus.IMEM_BUSYWAIT = 1'b0;
      @(negedge CLK);
      chk("sub_wr", {31'd0, WRITE}, 32'd1);
      chk("sub_op", {29'd0, ALUOP}, 32'd1);
      chk("sub_neg", {31'd0, NEG_SEL}, 32'd1);
      chk("sub_regs", {23'd0, INADDRESS, OUT1ADDRESS, OUT2ADDRESS}, {23'd0, 3'd4, 3'd1, 3'd3});
      chk("sub_isel", {31'd0, IMM_SEL}, 32'd0);
      @(negedge CLK);
      chk("sub_wr_off", {31'd0, WRITE}, 32'd0);
      chk("sub_writes", writes, 32'd2);
      run("and", 32'h8, 1'b1, 3'd2);
      run("or", 32'hC, 1'b1, 3'd3);
      chk("pre_beq_ill", {31'd0, ILLEGAL}, 32'd0);
      ZERO = 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
      run("beq_t", 32'h10, 1'b0, 3'd1);
      chk("beq_t_tgt", bus.PC, 32'hC);
      run("or2", 32'hC, 1'b1, 3'd3);
      ZERO = 1'b0;
      run("beq_n", 32'h10, 1'b0, 3'd1);
      chk("beq_ill", {31'd0, ILLEGAL}, 32'd0);
`else
      run("beq_x", 32'h10, 1'b0, 3'd0);
      chk("beq_ill", {31'd0, ILLEGAL}, 32'd1);
      ZERO = 1'b0;
`endif
      run("ill", 32'h14, 1'b0, 3'd0);
      chk("ill_flag", {31'd0, ILLEGAL}, 32'd1);
      chk("add_pc", bus.PC, 32'h18);
      @(negedge CLK);
      chk("add_wr", {31'd0, WRITE}, 32'd1);
      chk("add_ill_held", {31'd0, ILLEGAL}, 32'd1);
      #2 RESET = 1'b0;
      #1 chk("abort_wr", {31'd0, WRITE}, 32'd0);
      chk("abort_pc", bus.PC, 32'h0);
      chk("abort_ill", {31'd0, ILLEGAL}, 32'd0);
      @(negedge CLK);
      chk("abort_rd", {31'd0, bus.IMEM_READ}, 32'd0);
`ifdef CPU_CTRL_BRANCH_EN
      chk("total_writes", writes, 32'd5);
`else
      chk("total_writes", writes, 32'd4);
`endif
      RESET = 1'b1;
      @(negedge CLK);
      chk("refetch_pc", bus.PC, 32'h0);
      chk("refetch_rd", {31'd0, bus.IMEM_READ}, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_ctrl_unit.md
# cpu_ctrl_unit

Instruction fetch and control stage of the 8-bit CPU, sitting directly upstream of the register file and ALU. It holds the program counter and fetches 32-bit instructions from instruction memory over a busy-wait handshake. It latches each instruction into an instruction register and decodes it into the register-file controls (WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS) and the ALU/datapath controls, then computes the next PC, including taken branches.

## Interface
- No parameters; widths fixed by the ISA (8-bit data, 3-bit register addresses, 32-bit instruction and PC).
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- PC  out  32  current instruction address to instruction memory.
- IMEM_READ  out  1  instruction-memory read request.
- IMEM_BUSYWAIT  in  1  high while memory has not yet returned INSTRUCTION.
- INSTRUCTION  in  32  fetched instruction word.
- ZERO  in  1  ALU result == 0; used by beq.
- WRITE  out  1  register-file write enable.
- INADDRESS  out  3  destination register, IR[18:16].
- OUT1ADDRESS  out  3  source 1, IR[10:8].
- OUT2ADDRESS  out  3  source 2, IR[2:0].
- IMM  out  8  immediate, IR[7:0].
- ALUOP  out  3  000 FWD, 001 ADD, 010 AND, 011 OR.
- IMM_SEL  out  1  1 selects IMM as ALU operand 2.
- NEG_SEL  out  1  1 selects the two's complement of operand 2.
- ILLEGAL  out  1  sticky flag: an undefined opcode was executed.

## Operation
- Instruction fields: opcode IR[31:24]; branch offset IR[23:16], signed, counted in words.
- Opcodes:
  - 0x00 loadi: FWD, IMM_SEL=1, WRITE=1.
  - 0x01 mov: FWD, WRITE=1.
  - 0x02 add: ADD, WRITE=1.
  - 0x03 sub: ADD, NEG_SEL=1, WRITE=1.
  - 0x04 and: AND, WRITE=1.
  - 0x05 or: OR, WRITE=1.
  - 0x06 j: no write.
  - 0x07 beq: ADD, NEG_SEL=1, no write.
- FSM states IDLE, FETCH, EXEC.
  - IDLE: entered on reset. Goes to FETCH on the first posedge with RESET high.
  - FETCH: IMEM_READ=1, WRITE=0. On a posedge with IMEM_BUSYWAIT=0, IR<=INSTRUCTION and go to EXEC. Otherwise stay in FETCH.
  - EXEC: IMEM_READ=0. Controls are decoded combinationally from IR. On the posedge, PC<=next_pc and go to FETCH.
- next_pc:
  - Default: PC+4.
  - j: PC+4+(sext(offset)<<2).
  - beq: the same target if ZERO is sampled high at the EXEC posedge, else PC+4.
- Arithmetic is 32-bit modulo 2^32. Wrap past 0xFFFFFFFC to 0 is allowed and not flagged.
- Illegal opcode (0x08–0xFF): WRITE=0, ALUOP=000, all selects 0, PC+4. ILLEGAL is set at the EXEC posedge and cleared only by reset.
- WRITE is high only in EXEC, so the register file writes exactly once per write-type instruction, at the posedge that ends EXEC.

## Timing
- Reset values (held while RESET is low, applied immediately): state IDLE, PC=0, IR=0, IMEM_READ=0, WRITE=0, ILLEGAL=0.
- Decoded outputs are also forced to 0 in IDLE and FETCH.
- Latency: an instruction takes 2 cycles (FETCH and EXEC) plus one extra cycle per cycle IMEM_BUSYWAIT is high. The first fetch starts 1 cycle after reset release.
- IMEM_READ rises in the cycle FETCH is entered. It stays high until the posedge that samples IMEM_BUSYWAIT=0, and PC stays stable for that whole period.
- ZERO must be settled before the posedge that ends EXEC. This budget covers the register-file read delay plus the ALU delay.
- Reset asserted mid-FETCH or mid-EXEC aborts the instruction: no write, PC=0, state IDLE.
- IMEM_BUSYWAIT is ignored outside FETCH.

## Configuration
- CPU_CTRL_BRANCH_EN
  - Defined: j and beq decode and redirect the PC as described above.
  - Undefined: 0x06 and 0x07 are illegal opcodes (no write, PC+4, ILLEGAL set), and the ZERO input is unused.

## Structure
- Shared package cpu_pkg contains:
  - opcode constants OP_LOADI…OP_BEQ;
  - ALUOP codes ALU_FWD/ALU_ADD/ALU_AND/ALU_OR;
  - the state enum (IDLE, FETCH, EXEC).
- Sub-module cpu_ctrl_decode is purely combinational. It maps opcode to WRITE, ALUOP, IMM_SEL, NEG_SEL, is_jump, is_beq and is_illegal. The top level holds the FSM, PC, IR and ILLEGAL.

## Test plan
- Reset low, then high with IMEM_BUSYWAIT=0 → PC=0, IMEM_READ=0 in IDLE, rising in the next cycle; fetches proceed at PC=0, 4, 8.
- loadi R2,0x1F (0x0002001F) → EXEC: WRITE=1, INADDRESS=2, IMM=0x1F, IMM_SEL=1, ALUOP=000; next PC=4.
- sub R4,R1,R3 (0x03040103) with IMEM_BUSYWAIT high for 3 cycles → PC is held, FETCH lasts 4 cycles, WRITE is high for exactly 1 cycle with ALUOP=001 and NEG_SEL=1.
- beq offset 0xFE at PC=0x10 → with ZERO=1, next PC=0x0C; with ZERO=0, next PC=0x14. With CPU_CTRL_BRANCH_EN undefined → PC=0x14 and ILLEGAL=1.
- Opcode 0x2A → WRITE=0, ILLEGAL=1 and held across the following instructions, PC+4.
- RESET pulsed low during EXEC of add → WRITE drops immediately, PC=0, no register write occurs.
